// File: rtl/adder_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
//   state_t   : sequencer FSM state encoding (ST_IDLE / ST_RUN / ST_DONE)
//   NIBBLE_W  : width of the shared external adder slice
//   req_id_t  : requester identifier (0 or 1)
package adder_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   valid0_i, valid1_i    : request lines
//   advance_i             : a grant was consumed this cycle; the pointer moves
//   grant0_o, grant1_o    : combinational one-hot (or zero) grant
//   ptr_o                 : requester favoured when both request (0 after reset)
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic advance_i,
  output logic grant0_o,
  output logic grant1_o,
  output logic ptr_o
);

  logic ptr_q, ptr_d;

  // A lone requester always wins; on contention the pointer side wins.
  assign grant0_o = valid0_i & (~valid1_i | ~ptr_q);
  assign grant1_o = valid1_i & (~valid0_i |  ptr_q);
  assign ptr_o    = ptr_q;

  // After a grant is consumed, favour the requester that was not served.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = grant0_o;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/adder_nibble_sequencer.sv
// Schedules wide additions from two requesters onto one shared external
// 4-bit adder slice, one nibble per cycle, LSB nibble first, with the carry
// rippled through a register.
// Handshakes (requester ports and result port): a transfer happens in a
// cycle where valid and ready are both 1 at the rising clock edge; valid is
// held by the source until that happens, ready never depends on a transfer
// already having happened in the same cycle.
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   reqN_valid/ready/a/b/cin (N=0,1)  : requester operation ports
//   add_a, add_b, add_cin             : to the shared adder (0 outside RUN)
//   add_s, add_cout                   : combinational result of the shared adder
//   out_valid/ready/sum/cout/id       : result port
//   out_ovf                           : signed overflow (only with ADDSEQ_OVERFLOW_EN)
//   dbg_state                         : current FSM state (adder_seq_pkg encoding)
// Build option: define ADDSEQ_OVERFLOW_EN to add the out_ovf output.
module adder_nibble_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_id,
`ifdef ADDSEQ_OVERFLOW_EN
  output logic             out_ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  req_id_t          id_q, id_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             grant0, grant1, arb_ptr;
  logic             accept0, accept1;
  logic [WIDTH-1:0] a_shift, b_shift;

  rr_arb2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .valid0_i  (req0_valid),
    .valid1_i  (req1_valid),
    .advance_i (accept0 | accept1),
    .grant0_o  (grant0),
    .grant1_o  (grant1),
    .ptr_o     (arb_ptr)
  );

  // Ready is masked during reset so no transfer can be seen while the
  // sequencer is being cleared.
  assign req0_ready = ~reset & (state_q == ST_IDLE) & grant0;
  assign req1_ready = ~reset & (state_q == ST_IDLE) & grant1;
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;

  // Current nibble is brought down to bits [3:0]; shift is idx*4.
  assign a_shift = a_q >> {idx_q, 2'b00};
  assign b_shift = b_q >> {idx_q, 2'b00};

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == ST_RUN) begin
      add_a   = a_shift[3:0];
      add_b   = b_shift[3:0];
      add_cin = carry_q;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_id    = id_q;
  assign dbg_state = state_q;

`ifdef ADDSEQ_OVERFLOW_EN
  logic ovf_q, ovf_d;
  assign out_ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    id_d    = id_q;
    idx_d   = idx_q;
`ifdef ADDSEQ_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept0 | accept1) begin
          id_d    = accept1;
          a_d     = accept1 ? req1_a   : req0_a;
          b_d     = accept1 ? req1_b   : req0_b;
          carry_d = accept1 ? req1_cin : req0_cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IDX_W'(n)) sum_d[n*NIBBLE_W +: NIBBLE_W] = add_s;
        end
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = add_cout;
`ifdef ADDSEQ_OVERFLOW_EN
          // Carry into the top bit is a^b^s at bit 3 of the last nibble.
          ovf_d   = add_cout ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ add_s[3]);
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      idx_q   <= '0;
`ifdef ADDSEQ_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
`ifdef ADDSEQ_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // The pointer is kept inside the arbiter; it is not needed here.
  logic unused_ptr;
  assign unused_ptr = arb_ptr;

endmodule

// File: tb/tb_adder_nibble_sequencer.sv
// Bench for adder_nibble_sequencer: directed scenarios plus random traffic,
// checked against an arithmetic reference (full-width a+b+cin) and a
// round-robin "serve the other one on contention" rule.
module tb_adder_nibble_sequencer;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int EW    = WIDTH + 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_cin = 1'b0, req1_cin = 1'b0;
  logic [3:0]       add_a, add_b, add_s;
  logic             add_cin, add_cout;
  logic             out_valid, out_cout, out_id;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic [1:0]       dbg_state;
`ifdef ADDSEQ_OVERFLOW_EN
  logic             out_ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic hold_low = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // External shared 4-bit adder slice.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  adder_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_id(out_id),
`ifdef ADDSEQ_OVERFLOW_EN
    .out_ovf(out_ovf),
`endif
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drivers act at posedge+1 and return aligned to posedge+1.
  task automatic drive(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
  endtask

  task automatic wait_accept(input int id);
    int n = 0;
    logic got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clock);
      got = (id == 0) ? req0_ready : req1_ready;
      n++;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clock); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic issue(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    drive(id, a, b, cin);
    wait_accept(id);
  endtask

  // Consumer: random backpressure unless forced low.
  always @(posedge clock) begin
    #1;
    out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0]    exp_q[$];   // {ovf, id, cout, sum}
  int               acc_q[$];   // acceptance cycle per queued op
  logic             last_id = 1'b1;
  logic             prev_valid = 1'b0, prev_hs = 1'b0;
  logic [WIDTH-1:0] held_sum;
  logic             held_cout, held_id;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] ma, mb;
  logic             mcin, gid, movf;
  logic [EW-1:0]    e;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      last_id    = 1'b1;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (req0_ready && req1_ready) chk("ready_onehot", 2'b11, 2'b01);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        gid = req1_valid && req1_ready;
        if (req0_valid && req1_valid) chk("arb_pick", gid, !last_id);
        last_id = gid;
        ma   = gid ? req1_a : req0_a;
        mb   = gid ? req1_b : req0_b;
        mcin = gid ? req1_cin : req0_cin;
        full = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mcin};
        movf = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        exp_q.push_back({movf, gid, full[WIDTH], full[WIDTH-1:0]});
        acc_q.push_back(cyc);
      end
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) chk("spurious_valid", 1, 0);
        else chk("latency", cyc - acc_q.pop_front(), NIB + 1);
      end
      if (out_valid && prev_valid && !prev_hs) begin
        chk("hold_sum", out_sum, held_sum);
        chk("hold_cout", out_cout, held_cout);
        chk("hold_id", out_id, held_id);
      end
      if (out_valid) chk("ready_in_done", {req0_ready, req1_ready}, 2'b00);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sum", out_sum, e[WIDTH-1:0]);
          chk("cout", out_cout, e[WIDTH]);
          chk("id", out_id, e[WIDTH+1]);
`ifdef ADDSEQ_OVERFLOW_EN
          chk("ovf", out_ovf, e[WIDTH+2]);
`endif
        end
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      held_sum   = out_sum;
      held_cout  = out_cout;
      held_id    = out_id;
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (n >= 200) chk("drain_timeout", 1, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sum"}, out_sum, 0);
    chk({tag, "_out_cout"}, out_cout, 0);
    chk({tag, "_out_id"}, out_id, 0);
    chk({tag, "_add"}, {add_a, add_b, add_cin}, 0);
    chk({tag, "_state"}, dbg_state, 0);
`ifdef ADDSEQ_OVERFLOW_EN
    chk({tag, "_ovf"}, out_ovf, 0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle_outputs("rst");
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);

    // Both requesters pending as reset releases: req0 then req1.
    @(posedge clock); #1;
    drive(0, 16'h00F0, 16'h0F0F, 1'b1);
    drive(1, 16'hABCD, 16'h1111, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    fork
      wait_accept(0);
      wait_accept(1);
    join
    drain();

    // Directed sums.
    issue(0, 16'h1234, 16'h0FFF, 1'b0);
    drain();
    issue(1, 16'hFFFF, 16'h0000, 1'b1);
    for (int p = 0; p < NIB; p++) begin
      @(negedge clock);
      chk("ripple_cin", {add_cin, add_a, add_b}, {1'b1, 4'hF, 4'h0});
    end
    @(negedge clock);
    chk("add_zero_after_run", {add_cin, add_a, add_b}, 9'd0);
    drain();

    // Contention again after req1 was served last: req0 wins.
    @(posedge clock); #1;
    fork
      issue(0, 16'h5555, 16'h2222, 1'b0);
      issue(1, 16'h8000, 16'h8001, 1'b1);
    join
    drain();

    // Backpressure in DONE with a requester waiting.
    hold_low = 1'b1;
    @(posedge clock); #1;
    issue(0, 16'hBEEF, 16'h1001, 1'b1);
    drive(1, 16'h0102, 16'h0304, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(negedge clock); n++; end
      chk("done_reached", out_valid, 1);
    end
    repeat (5) begin
      @(negedge clock);
      chk("done_held_valid", out_valid, 1);
      chk("done_ready_low", {req0_ready, req1_ready}, 2'b00);
    end
    @(posedge clock); #1;
    hold_low = 1'b0;
    wait_accept(1);
    drain();

    // Reset in the 2nd RUN cycle aborts; requester re-presents afterwards.
    issue(0, 16'h4321, 16'h1111, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("abort");
    chk("abort_ready", {req0_ready, req1_ready}, 2'b00);
    @(posedge clock); #1;
    issue(0, 16'h4321, 16'h1111, 1'b0);
    drain();

    // Signed overflow corners (sum/cout checked in every build).
    issue(0, 16'h7FFF, 16'h0001, 1'b0);
    drain();
    issue(1, 16'hFFFF, 16'h0001, 1'b0);
    drain();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode == 0)      issue(0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      else if (mode == 1) issue(1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      else begin
        fork
          issue(0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
          issue(1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        join
      end
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_nibble_sequencer.md
Name: adder_nibble_sequencer

Overview:
Shares one external 4-bit adder slice (full_adder_4bit: A, B, C_in -> S, C_out) between two requesters and sequences wide additions through it nibble-serially, LSB nibble first, rippling carry through a register. A valid/ready handshake is used on each requester port and on the result port. Sits in the DSP datapath as the scheduler in front of the shared adder.

Parameters:
WIDTH, 16, operand/result width in bits; multiple of 4, minimum 4
NIB, WIDTH/4 (localparam), number of adder passes per operation

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  operand A
req0_b  input  WIDTH  operand B
req0_cin  input  1  carry in
req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0
add_a  output  4  to adder A
add_b  output  4  to adder B
add_cin  output  1  to adder C_in
add_s  input  4  from adder S (combinational)
add_cout  input  1  from adder C_out
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  result sum
out_cout  output  1  final carry out
out_id  output  1  requester that issued the result

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-high.
- Reset: state IDLE; out_valid=0, out_sum=0, out_cout=0, out_id=0; req*_ready=0; add_a/add_b/add_cin=0; RR pointer=0 (req0 favoured); nibble index=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: grant is combinational. If exactly one valid, that requester is granted. If both are valid, the pointer side is granted.
  - reqN_ready=1 only for the granted requester, only in IDLE.
  - On handshake (valid&ready), latch a, b, cin and id; set carry reg=cin and idx=0; go to RUN; the pointer moves to the other requester.
- RUN: add_a=a[4*idx+:4], add_b=b[4*idx+:4], add_cin=carry reg. Each cycle:
  - sum[4*idx+:4] <= add_s.
  - carry <= add_cout.
  - idx++.
  - After the pass with idx=NIB-1, go to DONE.
  - RUN lasts exactly NIB cycles.
- add_* outputs are 0 outside RUN.
- DONE: out_valid=1 with stable out_sum/out_cout/out_id until out_ready=1. On the out_ready handshake, go to IDLE; out_valid drops next cycle.
- Latency: accept at cycle T, out_valid at T+NIB+1.
- Throughput: at most one operation per NIB+2 cycles.
- No new request is accepted in RUN or DONE; requester valid is held by the requester.
- WIDTH=4 means a single RUN cycle.
- Sum wraps modulo 2^WIDTH; the carry out of the top nibble goes to out_cout.
- A requester deasserting valid without a handshake has no effect.
- reset asserted in RUN or DONE aborts the operation immediately. All outputs return to reset values next edge; the partial result is discarded.

Optional Feature:
ADDSEQ_OVERFLOW_EN
- Defined: adds output port out_ovf (1 bit), valid with out_valid. Signed overflow equals the carry into the top bit XOR out_cout, taken from the last RUN pass as add_cout XOR the carry into bit 3 of that nibble (a[W-1]^b[W-1]^sum[W-1]). out_ovf resets to 0.
- Undefined: the port and logic are absent; otherwise behaviour is identical.

Decomposition:
- Shared package adder_seq_pkg: FSM state typedef (IDLE/RUN/DONE), NIBBLE_W=4 constant, requester-id typedef.
- One sub-module, rr_arb2: two-input round-robin arbiter (valid0/valid1, advance -> grant0/grant1, pointer register). The pointer advances on the accept handshake.

Test Plan:
1. WIDTH=16. req0 a=0x1234 b=0x0FFF cin=0 -> after 4 RUN cycles out_sum=0x2233, out_cout=0, out_id=0; out_valid at accept+5.
2. req1 a=0xFFFF b=0x0000 cin=1 -> out_sum=0x0000, out_cout=1, out_id=1; carry ripples through all 4 passes (add_cin=1 each pass).
3. Both valid on the first cycle after reset with distinct operands -> req0 served first, req1 served next; then both valid again -> req0 (pointer back).
4. out_ready held 0 for 5 cycles in DONE -> out_valid, out_sum, out_id stable; req0_ready/req1_ready stay 0 despite valid; release -> IDLE, new accept.
5. reset pulsed during the 2nd RUN cycle -> next cycle all outputs 0, state IDLE; the pending requester is accepted afresh afterwards with the correct sum.
6. With ADDSEQ_OVERFLOW_EN: 0x7FFF+0x0001 cin=0 -> sum 0x8000, cout 0, out_ovf=1; 0xFFFF+0x0001 -> sum 0x0000, cout 1, out_ovf=0.
